// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters sharing one downstream
// resource. A rotating pointer sets the highest-priority index; the winner
// holds its grant until done, withdrawal or the hold limit, after which the
// pointer moves just past it and at least one idle cycle follows.
module rr_arbiter8 #(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req,
    input  logic [8*DATA_W-1:0] din,
    input  logic                done,
    output logic [7:0]          gnt,
    output logic [2:0]          gnt_id,
    output logic                gnt_valid,
    output logic [DATA_W-1:0]   dout,
    output logic                timeout
);

    // Hold counter only needs to reach MAX_HOLD-1.
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [2:0]          r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [7:0]          r_gnt;
    logic [2:0]          r_gnt_id;
    logic                r_gnt_valid;
    logic                r_timeout;

    state_t              w_state_nxt;
    logic [2:0]          w_ptr_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [7:0]          w_gnt_nxt;
    logic [2:0]          w_gnt_id_nxt;
    logic                w_gnt_valid_nxt;
    logic                w_timeout_nxt;

    logic                w_found;
    logic [2:0]          w_pick;
    logic                w_limit;
    logic                w_release;
    logic [DATA_W-1:0]   w_dout;

    // Rotated priority search: first requester at or after r_ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        logic [2:0] idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        idx     = r_ptr;
        for (int k = 0; k < 8; k++) begin
            idx = r_ptr + 3'(k);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    // Release and timeout qualification for the current owner.
    always_comb begin
        w_limit   = HOLD_EN && (r_hold_cnt == HOLD_LAST);
        w_release = done || !req[r_gnt_id] || w_limit;
    end

    // Next-state and next-output logic for the IDLE/GRANT sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_GRANT;
                    w_gnt_nxt       = 8'b1 << w_pick;
                    w_gnt_id_nxt    = w_pick;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt     = S_IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_id + 3'd1;
                    w_hold_nxt      = '0;
                    // Timeout is flagged only when the hold limit alone ended the grant.
                    w_timeout_nxt   = w_limit && !done && req[r_gnt_id];
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= '0;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // 8:1 data mux onto the shared bus, forced to zero when nobody owns it.
    always_comb begin
        w_dout = '0;
        if (r_gnt_valid) begin
            w_dout = din[r_gnt_id*DATA_W +: DATA_W];
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
    assign dout      = w_dout;

endmodule
